// File: rtl/cpu_insn_pkg.sv
// Shared moxie instruction constants and length decode.
// Used by cpu_fetch, cpu_ibuf_unpack and decode.
package cpu_insn_pkg;

  localparam logic [31:0] BOOT_ADDRESS = 32'h0000_1000;

  localparam int N_LONG = 18;

  localparam logic [N_LONG*8-1:0] LONG_OPS = {
    8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
    8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22,
    8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39
  };

  function automatic logic insn_is_long(
    input logic [15:0] opcode
  );
    logic hit;
    logic unused_lo;
    hit = 1'b0;
    unused_lo = ^opcode[7:0];
    for (int i = 0; i < N_LONG; i++) begin
      if (opcode[15:8] == LONG_OPS[i*8 +: 8])
        hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/cpu_insn_len.sv
// Opcode length decode: is_long=1 when a 32-bit operand follows.
// Ports: opcode (16b in), is_long (out).
module cpu_insn_len
  import cpu_insn_pkg::*;
(
  input  logic [15:0] opcode,
  output logic        is_long
);

  assign is_long = insn_is_long(opcode);

endmodule

// File: rtl/cpu_ibuf_unpack.sv
// Halfword instruction queue between fetch and decode.
// Ports: clk_i, rst_i(n), flush_*, write_*, read_en_i, head outputs.
module cpu_ibuf_unpack
  import cpu_insn_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [31:0] BOOT_PC = BOOT_ADDRESS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        write_en_i,
  input  logic [31:0] data_i,
  output logic        full_o,
  output logic        empty_o,
  input  logic        read_en_i,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic        valid_o,
  output logic [31:0] pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   head_pc;
  logic          skip_hi;

  logic [AW-1:0] rd_p1;
  logic [AW-1:0] rd_p2;
  logic [AW-1:0] wr_p1;
  logic [CW-1:0] free;
  logic [CW-1:0] n_push;
  logic [CW-1:0] n_pop;
  logic [CW-1:0] add;
  logic [CW-1:0] sub;
  logic          is_long;
  logic          wr_acc;
  logic          rd_acc;
  logic          unused_pc0;

  assign unused_pc0 = flush_pc_i[0];

  cpu_insn_len u_len (
    .opcode  (opcode_o),
    .is_long (is_long)
  );

  assign rd_p1 = rd_ptr + AW'(1);
  assign rd_p2 = rd_ptr + AW'(2);
  assign wr_p1 = wr_ptr + AW'(1);

  assign opcode_o  = mem[rd_ptr];
  assign operand_o = {mem[rd_p1], mem[rd_p2]};
  assign pc_o      = head_pc;

  assign free    = CW'(DEPTH) - count;
  assign full_o  = free < CW'(2);
  assign empty_o = count == CW'(0);
  assign valid_o = is_long ? (count >= CW'(3))
                           : (count >= CW'(1));

  // After a flush to a pc with bit 1 set, the next
  // fetched word's upper halfword precedes the target.
  assign n_push = skip_hi ? CW'(1) : CW'(2);
  assign n_pop  = is_long ? CW'(3) : CW'(1);

  assign wr_acc = write_en_i && !full_o;
  assign rd_acc = read_en_i && valid_o;

  assign add = wr_acc ? n_push : CW'(0);
  assign sub = rd_acc ? n_pop : CW'(0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 16'h0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      head_pc <= BOOT_PC;
      skip_hi <= 1'b0;
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      head_pc <= {flush_pc_i[31:1], 1'b0};
      skip_hi <= flush_pc_i[1];
    end else begin
      if (wr_acc) begin
        if (skip_hi) begin
          mem[wr_ptr] <= data_i[15:0];
        end else begin
          mem[wr_ptr] <= data_i[31:16];
          mem[wr_p1]  <= data_i[15:0];
        end
        wr_ptr  <= wr_ptr + n_push[AW-1:0];
        skip_hi <= 1'b0;
      end
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + n_pop[AW-1:0];
        head_pc <= head_pc + {31'(n_pop), 1'b0};
      end
      count <= count + add - sub;
    end
  end

endmodule

// File: tb/tb_cpu_ibuf_unpack.sv
// Randomized bench for cpu_ibuf_unpack.
// Reference model: a halfword queue with pc and skip state.
module tb_cpu_ibuf_unpack;

  localparam int DEPTH = 8;

  localparam logic [7:0] LONG_B [18] = '{
    8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
    8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22,
    8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39
  };

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        write_en_i;
  logic [31:0] data_i;
  logic        full_o;
  logic        empty_o;
  logic        read_en_i;
  logic [15:0] opcode_o;
  logic [31:0] operand_o;
  logic        valid_o;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] q [$];
  logic [15:0] src [$];
  logic [31:0] m_pc;
  logic        m_skip;
  logic        m_wr_ok;

  cpu_ibuf_unpack #(
    .DEPTH   (DEPTH),
    .BOOT_PC (32'h0000_1000)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .write_en_i (write_en_i),
    .data_i     (data_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .read_en_i  (read_en_i),
    .opcode_o   (opcode_o),
    .operand_o  (operand_o),
    .valid_o    (valid_o),
    .pc_o       (pc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic bit ref_long(input logic [15:0] op);
    bit hit;
    hit = 0;
    foreach (LONG_B[i])
      if (op[15:8] == LONG_B[i]) hit = 1;
    return hit;
  endfunction

  function automatic bit m_valid();
    if (q.size() == 0) return 0;
    if (ref_long(q[0])) return q.size() >= 3;
    return 1;
  endfunction

  function automatic bit m_full();
    return (DEPTH - q.size()) < 2;
  endfunction

  task automatic m_reset();
    q.delete();
    m_pc   = 32'h0000_1000;
    m_skip = 1'b0;
  endtask

  task automatic check_all();
    bit v;
    v = m_valid();
    check_eq("valid", 32'(valid_o), 32'(v));
    check_eq("empty", 32'(empty_o), 32'(q.size() == 0));
    check_eq("full", 32'(full_o), 32'(m_full()));
    check_eq("pc", pc_o, m_pc);
    if (q.size() >= 1)
      check_eq("opcode", 32'(opcode_o), 32'(q[0]));
    if (v && ref_long(q[0]))
      check_eq("operand", operand_o, {q[1], q[2]});
  endtask

  task automatic cycle(
    input logic        we,
    input logic [31:0] wd,
    input logic        re,
    input logic        fl,
    input logic [31:0] fpc
  );
    bit rd_ok;
    int n;
    write_en_i = we;
    data_i     = wd;
    read_en_i  = re;
    flush_i    = fl;
    flush_pc_i = fpc;
    rd_ok   = re && m_valid();
    m_wr_ok = we && !m_full() && !fl;
    n = (q.size() > 0 && ref_long(q[0])) ? 3 : 1;
    @(posedge clk_i);
    if (fl) begin
      q.delete();
      m_pc   = {fpc[31:1], 1'b0};
      m_skip = fpc[1];
    end else begin
      if (rd_ok) begin
        repeat (n) void'(q.pop_front());
        m_pc = m_pc + 32'(2 * n);
      end
      if (m_wr_ok) begin
        if (!m_skip) q.push_back(wd[31:16]);
        q.push_back(wd[15:0]);
        m_skip = 1'b0;
      end
    end
    #1;
    write_en_i = 1'b0;
    read_en_i  = 1'b0;
    flush_i    = 1'b0;
    check_all();
  endtask

  task automatic gen_insn();
    logic [7:0] b;
    if ($urandom_range(0, 1) == 1) begin
      b = LONG_B[$urandom_range(0, 17)];
      src.push_back({b, 8'($urandom)});
      src.push_back(16'($urandom));
      src.push_back(16'($urandom));
    end else begin
      do b = 8'($urandom);
      while (ref_long({b, 8'h00}));
      src.push_back({b, 8'($urandom)});
    end
  endtask

  function automatic logic [31:0] peek_word();
    return {src[0], src[1]};
  endfunction

  task automatic fill_src();
    while (src.size() < 2) gen_insn();
  endtask

  initial begin
    logic [31:0] w;
    rst_i      = 1'b0;
    flush_i    = 1'b0;
    flush_pc_i = 32'h0;
    write_en_i = 1'b0;
    data_i     = 32'h0;
    read_en_i  = 1'b0;
    m_reset();

    #23;
    check_all();
    check_eq("rst_opcode", 32'(opcode_o), 32'h0);
    check_eq("rst_operand", operand_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_all();
    check_eq("boot_pc", pc_o, 32'h0000_1000);

    cycle(1, 32'h2612_2734, 0, 0, 0);
    check_eq("t2_op0", 32'(opcode_o), 32'h2612);
    cycle(0, 0, 1, 0, 0);
    check_eq("t2_op1", 32'(opcode_o), 32'h2734);
    check_eq("t2_pc1", pc_o, 32'h1002);
    cycle(0, 0, 1, 0, 0);
    check_eq("t2_empty", 32'(empty_o), 32'h1);
    check_eq("t2_pc2", pc_o, 32'h1004);

    cycle(0, 0, 0, 1, 32'h0000_1000);
    cycle(1, 32'h0120_DEAD, 0, 0, 0);
    check_eq("t3_part", 32'(valid_o), 32'h0);
    check_eq("t3_nempty", 32'(empty_o), 32'h0);
    cycle(1, 32'hBEEF_0F00, 0, 0, 0);
    check_eq("t3_opnd", operand_o, 32'hDEAD_BEEF);
    cycle(0, 0, 1, 0, 0);
    check_eq("t3_op", 32'(opcode_o), 32'h0F00);
    check_eq("t3_pc", pc_o, 32'h1006);

    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    m_reset();
    check_all();
    check_eq("arst_opcode", 32'(opcode_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h2612_2734, 0, 0, 0);
      check_eq("t4_full", 32'(full_o), 32'(i == 3));
    end
    cycle(1, 32'h1111_2222, 0, 0, 0);
    check_eq("t4_drop", 32'(opcode_o), 32'h2612);
    cycle(0, 0, 1, 0, 0);
    check_eq("t4_c7", 32'(full_o), 32'h1);
    cycle(0, 0, 1, 0, 0);
    check_eq("t4_c6", 32'(full_o), 32'h0);

    cycle(1, 32'h5555_6666, 1, 1, 32'h0000_2002);
    check_eq("t5_empty", 32'(empty_o), 32'h1);
    check_eq("t5_pc", pc_o, 32'h2002);
    cycle(1, 32'hAAAA_0500, 0, 0, 0);
    check_eq("t5_op", 32'(opcode_o), 32'h0500);
    cycle(0, 0, 1, 0, 0);
    check_eq("t5_cnt1", 32'(empty_o), 32'h1);
    check_eq("t5_pc2", pc_o, 32'h2004);

    cycle(0, 0, 0, 1, 32'h0000_3000);
    for (int i = 0; i < 20; i++) begin
      fill_src();
      w = peek_word();
      cycle(1, w, 1, 0, 0);
      if (m_wr_ok) begin
        void'(src.pop_front());
        void'(src.pop_front());
      end else begin
        i--;
      end
    end
    repeat (6) cycle(0, 0, 1, 0, 0);

    src.delete();
    for (int i = 0; i < 400; i++) begin
      bit we;
      bit re;
      bit fl;
      logic [31:0] fpc;
      fill_src();
      we  = $urandom_range(0, 3) != 0;
      re  = $urandom_range(0, 2) != 0;
      fl  = $urandom_range(0, 40) == 0;
      fpc = (i == 200) ? 32'hFFFF_FFF2 : 32'($urandom);
      cycle(we, peek_word(), re, fl, fpc);
      if (fl) begin
        src.delete();
      end else if (m_wr_ok) begin
        void'(src.pop_front());
        void'(src.pop_front());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
